// File: rtl/arbiter_rr.sv
// Round-robin N-channel arbiter: serialises client read/write requests onto a
// single-port memory handshake bus, with an optional per-transaction timeout.
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 32
`endif

module arbiter_rr #(
    parameter int  WIDTH    = `MEMORY_WIDTH,
    parameter int  NCH      = 2,
    parameter int  AW       = 32,
    parameter int  MAX_WAIT = 0,
    localparam int GW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       ch_req,
    input  logic [NCH-1:0]       ch_rw,
    input  logic [NCH*AW-1:0]    ch_addr,
    input  logic [NCH*WIDTH-1:0] ch_wdata,
    output logic [NCH-1:0]       ch_ack,
    output logic [NCH-1:0]       ch_err,
    output logic [NCH*WIDTH-1:0] ch_rdata,
    output logic                 busy,
    output logic [GW-1:0]        grant_id,
    output logic                 mem_enable,
    output logic                 mem_rw,
    input  logic                 mem_ack,
    output logic [AW-1:0]        mem_addr,
    input  logic [WIDTH-1:0]     mem_data_out,
    output logic [WIDTH-1:0]     mem_data_in
);
    localparam int CW    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam int LIMIT = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;

    state_t        state, next_state;
    logic [GW-1:0] ptr;
    logic [GW-1:0] pick;
    logic          pick_valid;
    logic          done;
    logic          timeout;
    logic [CW-1:0] wait_cnt;

    assign mem_enable = (state == S_BUSY);
    assign busy       = (state == S_BUSY);

    // Scan from the highest offset down so the closest requester to ptr wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        pick_valid = 1'b0;
        pick       = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (ch_req[(int'(ptr) + k) % NCH]) begin
                pick_valid = 1'b1;
                pick       = GW'((int'(ptr) + k) % NCH);
            end
        end
    end

    always_comb begin
        next_state = state;
        done       = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_IDLE: if (pick_valid) next_state = S_BUSY;
            S_BUSY: begin
                if (mem_ack) begin
                    done = 1'b1;
                end else if (MAX_WAIT > 0 && wait_cnt == CW'(LIMIT)) begin
                    done    = 1'b1;
                    timeout = 1'b1;
                end
                if (done) next_state = S_ACK;
            end
            S_ACK:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: ch_rdata is a flop bank, not a RAM, so clearing it on reset is cheap and well defined.
            ptr         <= '0;
            grant_id    <= '0;
            ch_ack      <= '0;
            ch_err      <= '0;
            mem_rw      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            ch_rdata    <= '0;
            wait_cnt    <= '0;
        end else begin
            ch_ack <= '0;
            ch_err <= '0;
            case (state)
                S_IDLE: if (pick_valid) begin
                    grant_id    <= pick;
                    mem_addr    <= ch_addr[int'(pick)*AW +: AW];
                    mem_rw      <= ch_rw[pick];
                    mem_data_in <= ch_wdata[int'(pick)*WIDTH +: WIDTH];
                    wait_cnt    <= '0;
                end
                S_BUSY: if (done) begin
                    ch_ack[grant_id] <= 1'b1;
                    ch_err[grant_id] <= timeout;
                    ptr              <= GW'((int'(grant_id) + 1) % NCH);
                    // A timed-out read leaves the channel's previous data in place.
                    if (mem_ack && mem_rw)
                        ch_rdata[int'(grant_id)*WIDTH +: WIDTH] <= mem_data_out;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter_rr.sv
// Self-checking bench for arbiter_rr (4 channels, 5-cycle timeout): directed
// scenarios plus randomized traffic against a round-robin reference model.
module tb_arbiter_rr;
    localparam int NCH  = 4;
    localparam int W    = 32;
    localparam int AW   = 32;
    localparam int MAXW = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    ch_req, ch_rw, ch_ack, ch_err;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*W-1:0]  ch_wdata, ch_rdata;
    logic              busy, mem_enable, mem_rw, mem_ack;
    logic [1:0]        grant_id;
    logic [AW-1:0]     mem_addr;
    logic [W-1:0]      mem_data_out, mem_data_in;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         m_ptr;
    logic [W-1:0] m_rdata [NCH];

    always #5 clk = ~clk;

    arbiter_rr #(.WIDTH(W), .NCH(NCH), .AW(AW), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_rw(ch_rw),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_ack(ch_ack), .ch_err(ch_err),
        .ch_rdata(ch_rdata), .busy(busy), .grant_id(grant_id),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
    );

    // First requester in the rotated order ptr, ptr+1, ... (mod NCH).
    function automatic int model_grant(input logic [NCH-1:0] req, input int ptr);
        int order[$];
        for (int k = 0; k < NCH; k++) order.push_back((ptr + k) % NCH);
        foreach (order[j]) if (req[order[j]]) return order[j];
        return 0;
    endfunction

    task automatic apply_reset;
        reset        = 1'b1;
        ch_req       = '0;
        mem_ack      = 1'b0;
        mem_data_out = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;
        foreach (m_rdata[i]) m_rdata[i] = '0;
    endtask

    task automatic check_rdata(input string tag);
        for (int i = 0; i < NCH; i++) begin
            n_checks++;
            if (ch_rdata[i*W +: W] !== m_rdata[i]) begin
                n_fail++;
                $display("FAIL %s rdata[%0d]: got %h want %h", tag, i, ch_rdata[i*W +: W], m_rdata[i]);
            end
        end
    endtask

    // Runs one transaction from an IDLE negedge with ch_req nonzero; returns at the following IDLE negedge.
    task automatic serve(input int delay, input logic [W-1:0] rd, input bit scramble, output int got);
        int           g, en_cycles;
        bit           acked, exp_err;
        logic [AW-1:0] e_addr;
        logic [W-1:0]  e_wdata;
        logic          e_rw;
        logic [NCH-1:0] e_ack;
        g       = model_grant(ch_req, m_ptr);
        e_addr  = ch_addr[g*AW +: AW];
        e_rw    = ch_rw[g];
        e_wdata = ch_wdata[g*W +: W];
        exp_err = (delay > MAXW);
        e_ack   = '0;
        e_ack[g] = 1'b1;
        @(posedge clk); @(negedge clk);
        got = int'(grant_id);
        n_checks++;
        if (grant_id !== 2'(g)) begin n_fail++; $display("FAIL grant_id: got %0d want %0d", grant_id, g); end
        en_cycles = 0;
        acked     = 1'b0;
        for (int c = 1; c <= MAXW + 2 && !acked; c++) begin
            if (mem_enable === 1'b1) en_cycles++;
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL busy cycle %0d: got %b want 1", c, busy); end
            n_checks++;
            if (mem_addr !== e_addr) begin n_fail++; $display("FAIL mem_addr: got %h want %h", mem_addr, e_addr); end
            n_checks++;
            if (mem_rw !== e_rw) begin n_fail++; $display("FAIL mem_rw: got %b want %b", mem_rw, e_rw); end
            n_checks++;
            if (mem_data_in !== e_wdata) begin n_fail++; $display("FAIL mem_data_in: got %h want %h", mem_data_in, e_wdata); end
            mem_ack      = (c == delay);
            mem_data_out = (c == delay) ? rd : W'($urandom);
            if (scramble) begin
                ch_req[g] = 1'b0;
                ch_rw     = NCH'($urandom);
                ch_addr   = {$urandom, $urandom, $urandom, $urandom};
                ch_wdata  = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk); @(negedge clk);
            mem_ack = 1'b0;
            acked   = (ch_ack !== '0);
        end
        n_checks++;
        if (en_cycles != (exp_err ? MAXW : delay)) begin
            n_fail++; $display("FAIL mem_enable cycles: got %0d want %0d", en_cycles, exp_err ? MAXW : delay);
        end
        n_checks++;
        if (ch_ack !== e_ack) begin n_fail++; $display("FAIL ch_ack pulse: got %b want %b", ch_ack, e_ack); end
        n_checks++;
        if (ch_err !== (exp_err ? e_ack : '0)) begin
            n_fail++; $display("FAIL ch_err pulse: got %b want %b", ch_err, exp_err ? e_ack : '0);
        end
        n_checks++;
        if (mem_enable !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ack-cycle enable/busy: got %b/%b want 0/0", mem_enable, busy);
        end
        ch_req[g] = 1'b0;
        if (!exp_err && e_rw) m_rdata[g] = rd;
        m_ptr = (g + 1) % NCH;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (ch_ack !== '0 || ch_err !== '0 || mem_enable !== 1'b0) begin
            n_fail++; $display("FAIL post-ack idle: ack %b err %b en %b want 0 0 0", ch_ack, ch_err, mem_enable);
        end
        check_rdata("post-txn");
    endtask

    task automatic test_reset;
        apply_reset();
        n_checks++;
        if ({mem_enable, busy, mem_rw} !== 3'b000) begin
            n_fail++; $display("FAIL reset ctrl: got en/busy/rw %b want 000", {mem_enable, busy, mem_rw});
        end
        n_checks++;
        if (ch_ack !== '0 || ch_err !== '0) begin n_fail++; $display("FAIL reset ack/err: got %b/%b want 0/0", ch_ack, ch_err); end
        n_checks++;
        if (grant_id !== '0) begin n_fail++; $display("FAIL reset grant_id: got %0d want 0", grant_id); end
        n_checks++;
        if (mem_addr !== '0 || mem_data_in !== '0) begin
            n_fail++; $display("FAIL reset latches: addr %h data %h want 0", mem_addr, mem_data_in);
        end
        check_rdata("reset");
    endtask

    task automatic test_single_read;
        int got;
        ch_req = 4'b0001; ch_rw = 4'b0001;
        ch_addr[0 +: AW] = 32'h100;
        serve(3, 32'hA5A5_A5A5, 1'b0, got);
        n_checks++;
        if (ch_rdata[0 +: W] !== 32'hA5A5_A5A5 || ch_rdata[W +: W] !== '0) begin
            n_fail++; $display("FAIL single read: rdata0 %h rdata1 %h want a5a5a5a5 0", ch_rdata[0 +: W], ch_rdata[W +: W]);
        end
    endtask

    task automatic test_round_robin;
        int got;
        int exp_seq[4] = '{0, 1, 0, 1};
        apply_reset();
        for (int t = 0; t < 4; t++) begin
            ch_req = 4'b0011; ch_rw = 4'b0011;
            ch_addr = {$urandom, $urandom, $urandom, $urandom};
            serve(2, W'($urandom), 1'b0, got);
            n_checks++;
            if (got != exp_seq[t]) begin n_fail++; $display("FAIL rr order t=%0d: got %0d want %0d", t, got, exp_seq[t]); end
        end
    endtask

    task automatic test_write_hold;
        int got;
        ch_req = 4'b0010; ch_rw = 4'b0000;
        ch_addr[AW +: AW] = 32'h200;
        ch_wdata[W +: W]  = 32'h1234;
        serve(3, 32'hDEAD_BEEF, 1'b1, got);
        n_checks++;
        if (got != 1) begin n_fail++; $display("FAIL write grant: got %0d want 1", got); end
    endtask

    task automatic test_timeout;
        int got;
        ch_req = 4'b0100; ch_rw = 4'b1111;
        serve(99, 32'h5555_0000, 1'b0, got);
        ch_req = 4'b1000;
        serve(2, 32'h3333_3333, 1'b0, got);
        ch_req = 4'b0001;
        serve(MAXW, 32'h7777_1111, 1'b0, got);
    endtask

    task automatic test_reset_busy;
        int got;
        apply_reset();
        ch_req = 4'b0010; ch_rw = 4'b1111;
        serve(2, 32'hCAFE_0001, 1'b0, got);
        ch_req = 4'b1010;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (grant_id !== 2'd3 || mem_enable !== 1'b1) begin
            n_fail++; $display("FAIL pre-reset grant: got %0d en %b want 3 1", grant_id, mem_enable);
        end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;
        foreach (m_rdata[i]) m_rdata[i] = '0;
        n_checks++;
        if ({mem_enable, busy, mem_rw} !== 3'b000 || ch_ack !== '0 || ch_err !== '0) begin
            n_fail++; $display("FAIL mid-busy reset: en/busy/rw %b ack %b err %b want all 0",
                               {mem_enable, busy, mem_rw}, ch_ack, ch_err);
        end
        n_checks++;
        if (grant_id !== '0 || mem_addr !== '0 || mem_data_in !== '0) begin
            n_fail++; $display("FAIL mid-busy reset latches: gid %0d addr %h data %h want 0", grant_id, mem_addr, mem_data_in);
        end
        check_rdata("mid-busy reset");
        serve(1, 32'hBEEF_0002, 1'b0, got);
        n_checks++;
        if (got != 1) begin n_fail++; $display("FAIL post-reset grant: got %0d want 1", got); end
        ch_req = '0;
    endtask

    task automatic test_idle_ack;
        ch_req = '0;
        for (int c = 0; c < 3; c++) begin
            mem_ack = 1'b1; mem_data_out = W'($urandom);
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (ch_ack !== '0 || mem_enable !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL idle mem_ack: ack %b en %b busy %b want 0 0 0", ch_ack, mem_enable, busy);
            end
        end
        mem_ack = 1'b0;
        check_rdata("idle ack");
    endtask

    task automatic test_random;
        int got;
        for (int t = 0; t < 40; t++) begin
            ch_req = NCH'($urandom);
            if (ch_req == '0) ch_req[$urandom_range(0, NCH - 1)] = 1'b1;
            ch_rw    = NCH'($urandom);
            ch_addr  = {$urandom, $urandom, $urandom, $urandom};
            ch_wdata = {$urandom, $urandom, $urandom, $urandom};
            serve($urandom_range(1, MAXW + 2), W'($urandom), 1'($urandom_range(0, 1)), got);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: still running at %0t, limit 500000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; ch_req = '0; ch_rw = '0; ch_addr = '0; ch_wdata = '0;
        mem_ack = 1'b0; mem_data_out = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_hold();
        test_timeout();
        test_reset_busy();
        test_idle_ack();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/arbiter_rr.md
Name: arbiter_rr

Overview:
- Parametrised N-channel memory arbiter; successor to the fixed two-client (I-cache/D-cache) arbiter in the CPU memory path.
- Serialises read/write requests from NCH clients (caches, DMA, stdio bridge) onto the single-port memory handshake bus (mem_enable/mem_rw/mem_ack).
- Uses round-robin fairness instead of fixed priority.
- Adds an optional per-transaction timeout with error reporting.

Parameters:
- WIDTH, `MEMORY_WIDTH: memory line width in bits.
- NCH, 2: number of client channels (1..16).
- AW, 32: address width.
- MAX_WAIT, 0: maximum cycles to wait for mem_ack before aborting; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ch_req  input  NCH  per-channel request; level, held until ch_ack.
- ch_rw  input  NCH  per-channel direction; 1 = read, 0 = write.
- ch_addr  input  NCH*AW  per-channel address; channel i at [i*AW +: AW].
- ch_wdata  input  NCH*WIDTH  per-channel write data.
- ch_ack  output  NCH  one-cycle completion pulse per channel.
- ch_err  output  NCH  one-cycle timeout pulse, coincident with ch_ack.
- ch_rdata  output  NCH*WIDTH  per-channel registered read data.
- busy  output  1  high while a transaction is outstanding (state BUSY).
- grant_id  output  max(1,clog2(NCH))  index of the current or last granted channel.
- mem_enable  output  1  memory request.
- mem_rw  output  1  1 = read, 0 = write.
- mem_ack  input  1  memory completion, sampled on clk.
- mem_addr  output  AW  latched address.
- mem_data_out  input  WIDTH  read data from memory; valid while mem_ack=1.
- mem_data_in  output  WIDTH  latched write data to memory.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; rr pointer = 0; grant_id = 0.
  - ch_ack, ch_err, mem_enable, busy, mem_rw = 0.
  - mem_addr, mem_data_in, ch_rdata, wait counter = 0.
  - Reset asserted mid-transaction abandons it: no ack and no err for the victim.
- State IDLE:
  - If any ch_req is set, grant the first requesting index scanning ptr, ptr+1, …, wrapping mod NCH.
  - Latch that channel's addr, rw and wdata into mem_addr/mem_rw/mem_data_in; set grant_id.
  - Next state BUSY; mem_enable = 1 and busy = 1 from the next cycle.
  - No requests: stay IDLE.
- State BUSY:
  - mem_enable stays high; the latched outputs stay stable regardless of ch_req/ch_addr changes.
  - On mem_ack = 1:
    - If read, load mem_data_out into the granted channel's ch_rdata slice.
    - Pulse ch_ack[grant] = 1 the next cycle.
    - ptr = (grant+1) mod NCH.
    - Next state ACK; mem_enable drops the next cycle.
  - Timeout (MAX_WAIT > 0):
    - Wait counter increments each BUSY cycle without ack.
    - When the counter reaches MAX_WAIT, behave as on ack, but leave ch_rdata unchanged and pulse ch_err[grant] together with ch_ack.
  - mem_ack and timeout in the same cycle: ack wins, no err.
- State ACK:
  - ch_ack/ch_err high exactly this one cycle; mem_enable = 0; busy = 0.
  - Request sampling is blocked here.
  - Next state IDLE.
  - Clients must deassert req in the ack cycle; a req still high in IDLE is treated as a new request.
- Latency: req seen at edge 0 → mem_enable high after edge 0 → ack pulse one cycle after the mem_ack cycle → IDLE the cycle after.
  - Minimum turnaround: 3 cycles per transaction.
  - Back-to-back requests: mem_enable is low for 2 cycles between transactions.
- mem_ack outside BUSY is ignored.
- A write never modifies ch_rdata.
- ch_rdata[i] holds its value until the next completed read for channel i.
- Dropping ch_req during BUSY does not cancel the transaction; ack still pulses.
- NCH = 1: round-robin degenerates to that single channel; grant_id is 1 bit and constant 0.
- At most one bit of ch_ack is set at any time.

Test Plan:
- Reset, NCH=2: ch0 read at addr 0x100; memory acks after 3 cycles with data 0xA5..A5 → mem_enable high 3 cycles, mem_rw=1, mem_addr=0x100; ch_ack=2'b01 for one cycle; ch_rdata[0]=0xA5..A5; ch_rdata[1] stays 0.
- ch0 and ch1 request in the same cycle, both held through ack, ptr=0 → ch0 served first, then ch1; a third round with both requesting grants ch0 again (alternation 0,1,0,1 confirmed over 4 transactions).
- NCH=4: ch1 write 0x200 with data 0x1234; ch1 drops req and changes ch_addr mid-BUSY → mem_addr stays 0x200, mem_data_in stays 0x1234, mem_rw=0; ch_ack[1] still pulses; ch_rdata unchanged.
- MAX_WAIT=5, memory never acks → mem_enable high exactly 5 cycles, ch_ack and ch_err pulse together; the next request is accepted. Separately, mem_ack arriving on the 5th cycle → ack only, no err.
- Reset asserted during BUSY → next cycle all outputs 0 and no ack/err pulse; a request held after reset is granted with ptr=0.
- mem_ack pulsed while IDLE with no request → no ch_ack, ch_rdata unchanged, state stays IDLE.
